// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants, receiver FSM state type and the
// bit-period helper used by uart_rx (and by uart_tx once it migrates).
package uart_pkg;

    localparam int UART_CLK_FREQ = 100_000_000;
    localparam int UART_BAUD     = 115_200;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    // Clocks per bit period, truncated (868 for the defaults).
    function automatic int clk_per_bit(input int clk_freq,
                                       input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for one asynchronous input bit.
// Ports: clk, rst (sync, active high), d (async in), q (synced out).
// RST_VAL sets the value both flops take in reset.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, LSB first, idle-high line.
// Ports: clk, rst (sync, active high), rx (async pin) ->
//   data[7:0] (last good byte), valid / frame_err (1-cycle pulses),
//   busy (start detected until back in IDLE).
// Build option: define UART_RX_MAJORITY_EN for 2-of-3 bit voting.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = UART_CLK_FREQ,
    parameter int BAUD     = UART_BAUD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int CLK_PER_BIT = clk_per_bit(CLK_FREQ, BAUD);
    localparam int CW          = $clog2(CLK_PER_BIT);

    localparam logic [CW-1:0] HALF_LOAD = CW'(CLK_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LOAD  = CW'(CLK_PER_BIT - 1);

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic [2:0]    bit_idx;
    logic [2:0]    bit_idx_nx;
    logic [7:0]    shreg;
    logic [7:0]    shreg_nx;
    logic [7:0]    data_nx;
    logic          valid_nx;
    logic          ferr_nx;
    logic          busy_nx;

    logic rx_s;
    logic rx_prev;
    logic bit_val;
    logic fall;
    logic expire;

    sync_2ff #(
        .RST_VAL(1'b1)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (rx),
        .q  (rx_s)
    );

`ifdef UART_RX_MAJORITY_EN
    // Vote over the last three rx_s samples (counter at 2, 1, 0),
    // so the decision still lands on the same expiry clock.
    logic rx_prev2;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_prev2 <= 1'b1;
        end else begin
            rx_prev2 <= rx_prev;
        end
    end

    assign bit_val = (rx_prev2 & rx_prev) |
                     (rx_prev2 & rx_s)    |
                     (rx_prev  & rx_s);
`else
    assign bit_val = rx_s;
`endif

    assign fall   = rx_prev & ~rx_s;
    assign expire = (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_prev   <= 1'b1;
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            rx_prev   <= rx_s;
            state     <= state_nx;
            cnt       <= cnt_nx;
            bit_idx   <= bit_idx_nx;
            shreg     <= shreg_nx;
            data      <= data_nx;
            valid     <= valid_nx;
            frame_err <= ferr_nx;
            busy      <= busy_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        bit_idx_nx = bit_idx;
        shreg_nx   = shreg;
        data_nx    = data;
        valid_nx   = 1'b0;
        ferr_nx    = 1'b0;

        if (state != IDLE && !expire) begin
            cnt_nx = cnt - 1'b1;
        end

        unique case (state)
            IDLE: begin
                if (fall) begin
                    state_nx = START;
                    cnt_nx   = HALF_LOAD;
                end
            end
            START: begin
                if (expire) begin
                    if (!bit_val) begin
                        state_nx   = DATA;
                        bit_idx_nx = '0;
                        cnt_nx     = BIT_LOAD;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            DATA: begin
                if (expire) begin
                    shreg_nx   = {bit_val, shreg[7:1]};
                    cnt_nx     = BIT_LOAD;
                    bit_idx_nx = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) begin
                        state_nx = STOP;
                    end
                end
            end
            STOP: begin
                if (expire) begin
                    state_nx = IDLE;
                    if (bit_val) begin
                        data_nx  = shreg;
                        valid_nx = 1'b1;
                    end else begin
                        ferr_nx = 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase

        // Held through the pulse cycle so busy drops one clock later.
        busy_nx = (state_nx != IDLE) | valid_nx | ferr_nx;
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx with a bit-level
// serial source, expectation table and event scoreboard.
module tb_uart_rx;

    localparam int CLK_FREQ = 3_686_400;
    localparam int BAUD     = 115_200;
    localparam int N        = 32;
    localparam int H        = N / 2;
    // Drive happens 1 clock before the first edge that sees it,
    // then 2 sync stages, half a bit, 9 full bits.
    localparam int LAT      = 1 + 2 + H + 9 * N;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         gap;
        logic       err;
        logic [7:0] exp;
    } vec_t;

    typedef struct {
        logic       err;
        logic [7:0] data;
        int         at;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    int   checks;
    int   errors;
    int   cyc;
    int   n_evt;
    logic prev_evt;
    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[$];

    uart_rx #(
        .CLK_FREQ(CLK_FREQ),
        .BAUD    (BAUD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .data     (data),
        .valid    (valid),
        .frame_err(frame_err),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h",
                     name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (prev_evt) chk("busy_after_evt", busy, 0);
        prev_evt = 1'b0;
        if (valid || frame_err) begin
            n_evt++;
            prev_evt = 1'b1;
            chk("valid_ferr_excl", valid & frame_err, 0);
            chk("busy_at_evt", busy, 1);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event valid %0b ferr %0b",
                         valid, frame_err);
            end else begin
                mon_e = sb.pop_front();
                chk("evt_kind", frame_err, mon_e.err);
                chk("evt_data", data, mon_e.data);
                chk("evt_cycle", cyc, mon_e.at);
            end
        end
    end

    task automatic put_bit(input logic v);
        rx = v;
        repeat (N) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic stop);
        put_bit(1'b0);
        for (int i = 0; i < 8; i++) put_bit(b[i]);
        put_bit(stop);
    endtask

    task automatic expect_evt(input logic err, input logic [7:0] d);
        exp_t e;
        e.err  = err;
        e.data = d;
        e.at   = cyc + LAT;
        sb.push_back(e);
    endtask

    task automatic drain();
        for (int i = 0; i < 12 * N && sb.size() != 0; i++)
            @(negedge clk);
        chk("drain", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

`ifdef UART_RX_MAJORITY_EN
    // Inverts the line for one clock on the edge the single-sample
    // build would use.
    task automatic put_bit_g(input logic v);
        rx = v;
        repeat (H) @(posedge clk);
        #1 rx = ~v;
        @(posedge clk);
        #1 rx = v;
        repeat (N - H - 1) @(posedge clk);
        #1;
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        string s;
        int    n0;
        checks   = 0;
        errors   = 0;
        cyc      = 0;
        n_evt    = 0;
        prev_evt = 1'b0;
        rst      = 1'b1;
        rx       = 1'b1;

        vecs.push_back('{8'h55, 1'b1, 2, 1'b0, 8'h55});
        vecs.push_back('{8'hA3, 1'b0, 2, 1'b1, 8'h55});
        vecs.push_back('{8'h00, 1'b1, 0, 1'b0, 8'h00});
        vecs.push_back('{8'hFF, 1'b1, 2, 1'b0, 8'hFF});
        vecs.push_back('{8'h40, 1'b1, 0, 1'b0, 8'h40});
        s = "Pozdrowienia";
        for (int i = 0; i < s.len(); i++)
            vecs.push_back('{s[i], 1'b1, 0, 1'b0, s[i]});
        vecs[vecs.size() - 1].gap = 2;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_data", data, 0);
        chk("rst_valid", valid, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            expect_evt(vecs[i].err, vecs[i].exp);
            send(vecs[i].data, vecs[i].stop);
            for (int g = 0; g < vecs[i].gap; g++) put_bit(1'b1);
        end
        drain();

        n0 = n_evt;
        rx = 1'b0;
        repeat (8) @(posedge clk);
        #1 rx = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("fs_busy_high", busy, 1);
        repeat (H + 8) @(posedge clk);
        @(negedge clk);
        chk("fs_busy_low", busy, 0);
        chk("fs_no_event", n_evt, n0);
        @(posedge clk);
        #1;

        put_bit(1'b0);
        for (int i = 0; i < 4; i++) put_bit(1'b0);
        rx = 1'b1;
        repeat (H) @(posedge clk);
        @(negedge clk);
        chk("mid_busy", busy, 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_data", data, 0);
        chk("mid_rst_valid", valid, 0);
        chk("mid_rst_ferr", frame_err, 0);
        chk("mid_rst_busy", busy, 0);
        rst = 1'b0;
        repeat (2 * N) @(posedge clk);
        #1;
        chk("mid_rst_quiet", busy, 0);

        expect_evt(1'b0, 8'h3C);
        send(8'h3C, 1'b1);
        put_bit(1'b1);
        drain();

`ifdef UART_RX_MAJORITY_EN
        expect_evt(1'b0, 8'h5A);
        put_bit_g(1'b0);
        for (int i = 0; i < 8; i++) put_bit_g(s[0][i] ^ s[0][i] ^ 8'h5A >> i);
        put_bit_g(1'b1);
        put_bit(1'b1);
        drain();
`endif

        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
